// File: rtl/ccff_loader_pkg.sv
// Shared types and CRC helpers for the CCFF chain loader.
// The CRC items are only referenced when CFG_CRC_EN is defined.
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StDone,
        StError
    } state_e;

    localparam logic [15:0] Crc16Poly = 16'h1021;
    localparam logic [15:0] Crc16Init = 16'hFFFF;

    // CRC-16-CCITT, MSB-first, one input bit per call.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic [15:0] shifted;
        shifted = {crc[14:0], 1'b0};
        return (crc[15] ^ din) ? (shifted ^ Crc16Poly) : shifted;
    endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word handshake between the bitstream source (master) and the loader (slave).
interface ccff_chain_loader_if #(
    parameter int unsigned WORD_W = 8
) ();
    import ccff_loader_pkg::*;

    logic [WORD_W-1:0] din;
    logic              din_valid;
    logic              din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);

endinterface

// File: rtl/ccff_word_serializer.sv
// One-word buffer that accepts bitstream words and emits them LSB first, one bit per cycle.
// Only as many bits as the chain still needs are kept from each word.
module ccff_word_serializer
    import ccff_loader_pkg::*;
#(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned BlW    = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              flush_i,
    input  logic [BlW-1:0]    bits_left_i,
    input  logic [WORD_W-1:0] din_i,
    input  logic              din_valid_i,
    output logic              din_ready_o,
    output logic              shift_o,
    output logic              head_o
);

    localparam int unsigned CntW = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] buf_q, buf_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              head_q, head_d;
    logic              take;
    logic [31:0]       need;

    always_comb begin
        shift_o     = en_i && (cnt_q != '0);
        // Refill when the buffer is empty or its last bit leaves this cycle.
        din_ready_o = en_i && (cnt_q <= CntW'(1)) && (32'(bits_left_i) > 32'(cnt_q));
        take        = din_ready_o && din_valid_i;
        need        = 32'(bits_left_i) - 32'(cnt_q);
        head_o      = shift_o ? buf_q[0] : head_q;

        buf_d  = buf_q;
        cnt_d  = cnt_q;
        head_d = head_q;
        if (shift_o) begin
            buf_d  = buf_q >> 1;
            cnt_d  = cnt_q - CntW'(1);
            head_d = buf_q[0];
        end
        if (take) begin
            buf_d = din_i;
            cnt_d = (need > WORD_W) ? CntW'(WORD_W) : CntW'(need);
        end
        if (flush_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_q  <= '0;
            cnt_q  <= '0;
            head_q <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration sequencer: serializes bitstream words onto the CCFF chain head and flags completion.
// Define CFG_CRC_EN to add a CRC-16-CCITT check of the shifted stream (crc_expected / crc_err).
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN  = 64,
    parameter int unsigned WORD_W     = 8,
    parameter int unsigned SETTLE_CYC = 2,
    localparam int unsigned BlW       = $clog2(CHAIN_LEN + 1)
) (
    input  logic                prog_clock,
    input  logic                pReset,
    input  logic                start,
    input  logic                abort,
    ccff_chain_loader_if.slave  bus,
    output logic                ccff_head,
    output logic                config_enable,
    output logic                CFG_DONE,
    output logic                busy,
    output logic [BlW-1:0]      bits_left
`ifdef CFG_CRC_EN
    ,
    input  logic [15:0]         crc_expected,
    output logic                crc_err
`endif
);

    localparam int unsigned ScW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_e         state_q, state_d;
    logic [BlW-1:0] bits_left_q, bits_left_d;
    logic [ScW-1:0] settle_q, settle_d;
    logic           load_start;
    logic           active;
    logic           ser_en;
    logic           ser_flush;
    logic           ser_shift;
    logic           din_ready;
    logic           crc_pass_load;
    logic           crc_pass_settle;

    assign active     = (state_q == StLoad) || (state_q == StSettle);
    assign load_start = !active && start && !abort;
    assign ser_en     = (state_q == StLoad) && !abort;
    assign ser_flush  = load_start || (active && abort);

    ccff_word_serializer #(
        .WORD_W (WORD_W),
        .BlW    (BlW)
    ) u_ser (
        .clk_i       (prog_clock),
        .rst_i       (pReset),
        .en_i        (ser_en),
        .flush_i     (ser_flush),
        .bits_left_i (bits_left_q),
        .din_i       (bus.din),
        .din_valid_i (bus.din_valid),
        .din_ready_o (din_ready),
        .shift_o     (ser_shift),
        .head_o      (ccff_head)
    );

    assign bus.din_ready = din_ready;
    assign config_enable = ser_shift;
    assign CFG_DONE      = (state_q == StDone);
    assign busy          = active;
    assign bits_left     = bits_left_q;

`ifdef CFG_CRC_EN
    logic [15:0] crc_q, crc_d, crc_exp_q;

    always_comb begin
        crc_d = crc_q;
        if (load_start) begin
            crc_d = Crc16Init;
        end else if (ser_shift) begin
            crc_d = crc16_step(crc_q, ccff_head);
        end
    end

    always_ff @(posedge prog_clock or posedge pReset) begin
        if (pReset) begin
            crc_q     <= Crc16Init;
            crc_exp_q <= '0;
        end else begin
            crc_q <= crc_d;
            if (load_start) begin
                crc_exp_q <= crc_expected;
            end
        end
    end

    // With no settle time the final bit is still in flight when the verdict is taken.
    assign crc_pass_load   = (crc16_step(crc_q, ccff_head) == crc_exp_q);
    assign crc_pass_settle = (crc_q == crc_exp_q);
    assign crc_err         = (state_q == StError);
`else
    assign crc_pass_load   = 1'b1;
    assign crc_pass_settle = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        bits_left_d = bits_left_q;
        settle_d    = settle_q;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (load_start) begin
                    state_d     = StLoad;
                    bits_left_d = BlW'(CHAIN_LEN);
                end
            end
            StLoad: begin
                if (abort) begin
                    state_d     = StIdle;
                    bits_left_d = '0;
                end else if (ser_shift) begin
                    bits_left_d = bits_left_q - BlW'(1);
                    if (bits_left_q == BlW'(1)) begin
                        settle_d = '0;
                        if (SETTLE_CYC == 0) begin
                            state_d = crc_pass_load ? StDone : StError;
                        end else begin
                            state_d = StSettle;
                        end
                    end
                end
            end
            StSettle: begin
                if (abort) begin
                    state_d     = StIdle;
                    bits_left_d = '0;
                end else if (32'(settle_q) + 1 >= SETTLE_CYC) begin
                    state_d = crc_pass_settle ? StDone : StError;
                end else begin
                    settle_d = settle_q + ScW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge prog_clock or posedge pReset) begin
        if (pReset) begin
            state_q     <= StIdle;
            bits_left_q <= '0;
            settle_q    <= '0;
        end else begin
            state_q     <= state_d;
            bits_left_q <= bits_left_d;
            settle_q    <= settle_d;
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: 20-bit chain, 8-bit words 0xA5, 0x3C, 0xF7.
module tb_ccff_chain_loader;

    localparam int unsigned ChainLen  = 20;
    localparam int unsigned WordW     = 8;
    localparam int unsigned SettleCyc = 2;
    localparam int unsigned BlW       = $clog2(ChainLen + 1);

    logic           prog_clock = 1'b0;
    logic           pReset     = 1'b1;
    logic           start      = 1'b0;
    logic           abort      = 1'b0;
    logic           ccff_head, config_enable, CFG_DONE, busy;
    logic [BlW-1:0] bits_left;
`ifdef CFG_CRC_EN
    logic [15:0]    crc_expected = 16'h0000;
    logic           crc_err;
`endif

    ccff_chain_loader_if #(.WORD_W(WordW)) bus ();

    ccff_chain_loader #(
        .CHAIN_LEN  (ChainLen),
        .WORD_W     (WordW),
        .SETTLE_CYC (SettleCyc)
    ) dut (
        .prog_clock    (prog_clock),
        .pReset        (pReset),
        .start         (start),
        .abort         (abort),
        .bus           (bus),
        .ccff_head     (ccff_head),
        .config_enable (config_enable),
        .CFG_DONE      (CFG_DONE),
        .busy          (busy),
        .bits_left     (bits_left)
`ifdef CFG_CRC_EN
        ,
        .crc_expected  (crc_expected),
        .crc_err       (crc_err)
`endif
    );

    always #5 prog_clock = ~prog_clock;

    // Word stream, word 0 in the low byte; bit i of this vector is the i-th bit shifted.
    logic [23:0] stream = 24'hF73CA5;
    logic [7:0]  words [3];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int en_cnt = 0;
    int stall_cnt = 0;
    int last_shift_cyc = 0;
    logic done_prev = 1'b0;
    bit exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_crc(input logic [23:0] s);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < int'(ChainLen); i++) begin
            fb = c[15] ^ s[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    initial forever begin
        @(posedge prog_clock);
        cyc++;
    end

    // Monitor: every enabled shift must present the next expected bit.
    initial forever begin
        @(negedge prog_clock);
        if (!pReset) begin
            if (config_enable) begin
                en_cnt++;
                if (int'(bits_left) == 1) last_shift_cyc = cyc;
                chk("exp_q_nonempty", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("ccff_head", ccff_head, exp_q.pop_front());
            end else if (busy && bits_left != 0 && int'(bits_left) != int'(ChainLen)) begin
                stall_cnt++;
            end
            if (CFG_DONE && !done_prev) chk("done_latency", cyc - last_shift_cyc, SettleCyc + 1);
            done_prev = CFG_DONE;
        end else begin
            done_prev = 1'b0;
        end
    end

    // kind: 0 plain, 1 abort at bits_left==at, 2 start while busy at bits_left==at,
    // 3 start+abort at bits_left==at, 4 async reset in first SETTLE cycle.
    task automatic do_load(input int stall_len, input int kind, input int at, input bit exp_err);
        int   widx = 0;
        int   stall_left = stall_len;
        int   acc = 0;
        int   guard = 0;
        bit   ended = 0;
        bit   chk_next = 0;
        bit   rdy;
        int   bl;

        exp_q.delete();
        for (int i = 0; i < int'(ChainLen); i++) exp_q.push_back(stream[i]);
        en_cnt    = 0;
        stall_cnt = 0;

        @(negedge prog_clock);
        #1 start = 1'b1;
        @(negedge prog_clock);
        chk("start_busy", busy, 1);
        chk("start_bits_left", bits_left, ChainLen);
        chk("start_cfg_done", CFG_DONE, 0);
`ifdef CFG_CRC_EN
        chk("start_crc_err", crc_err, 0);
`endif

        while (guard < 200) begin
            guard++;
            if (chk_next) begin
                chk("ignored_start_bits_left", bits_left, at - 1);
                chk("ignored_start_busy", busy, 1);
                chk_next = 0;
            end
`ifdef CFG_CRC_EN
            if (CFG_DONE || crc_err) begin
`else
            if (CFG_DONE) begin
`endif
                ended = 1;
                break;
            end
            rdy = bus.din_ready;
            bl  = int'(bits_left);
            if (kind == 4 && busy && bl == 0) begin
                #1;
                pReset        = 1'b1;
                bus.din_valid = 1'b0;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_cfg_done", CFG_DONE, 0);
                chk("rst_bits_left", bits_left, 0);
                chk("rst_config_enable", config_enable, 0);
                chk("rst_ccff_head", ccff_head, 0);
                chk("rst_din_ready", bus.din_ready, 0);
                @(negedge prog_clock);
                #1 pReset = 1'b0;
                exp_q.delete();
                return;
            end
            #1;
            start = 1'b0;
            if (widx < 3) begin
                if (widx == 1 && stall_left > 0) begin
                    bus.din_valid = 1'b0;
                    if (rdy) stall_left--;
                end else begin
                    bus.din       = words[widx];
                    bus.din_valid = 1'b1;
                    if (rdy) begin
                        widx++;
                        acc++;
                    end
                end
            end else begin
                bus.din_valid = 1'b0;
            end
            if ((kind == 1 || kind == 3) && bl == at) begin
                abort         = 1'b1;
                start         = (kind == 3);
                bus.din_valid = 1'b0;
                @(negedge prog_clock);
                chk("abort_busy", busy, 0);
                chk("abort_bits_left", bits_left, 0);
                chk("abort_config_enable", config_enable, 0);
                chk("abort_cfg_done", CFG_DONE, 0);
                #1;
                abort = 1'b0;
                start = 1'b0;
                exp_q.delete();
                return;
            end
            if (kind == 2 && bl == at) begin
                start    = 1'b1;
                chk_next = 1;
            end
            @(negedge prog_clock);
        end

        chk("load_completed", ended, 1);
        #1 bus.din_valid = 1'b0;
        if (exp_err) begin
`ifdef CFG_CRC_EN
            chk("err_crc_err", crc_err, 1);
`endif
            chk("err_cfg_done", CFG_DONE, 0);
        end else begin
            chk("end_cfg_done", CFG_DONE, 1);
        end
        chk("end_busy", busy, 0);
        chk("end_din_ready", bus.din_ready, 0);
        chk("end_bits_left", bits_left, 0);
        chk("enable_cycles", en_cnt, ChainLen);
        chk("stall_cycles", stall_cnt, stall_len);
        chk("words_accepted", acc, 3);
        chk("bits_unshifted", exp_q.size(), 0);
    endtask

    initial begin
        words[0]      = stream[7:0];
        words[1]      = stream[15:8];
        words[2]      = stream[23:16];
        bus.din       = '0;
        bus.din_valid = 1'b0;
`ifdef CFG_CRC_EN
        crc_expected = model_crc(stream);
`endif
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_cfg_done", CFG_DONE, 0);
        chk("reset_bits_left", bits_left, 0);
        chk("reset_config_enable", config_enable, 0);
        chk("reset_din_ready", bus.din_ready, 0);
        chk("reset_ccff_head", ccff_head, 0);
        @(negedge prog_clock);
        #1 pReset = 1'b0;

        do_load(0, 0, 0, 0);
        do_load(5, 0, 0, 0);
        do_load(0, 1, 7, 0);
        do_load(0, 0, 0, 0);
        do_load(0, 2, 12, 0);
        do_load(0, 3, 12, 0);
        do_load(0, 0, 0, 0);
        do_load(0, 4, 0, 0);
        do_load(0, 0, 0, 0);
`ifdef CFG_CRC_EN
        crc_expected = model_crc(stream) ^ 16'h0010;
        do_load(0, 0, 0, 1);
        crc_expected = model_crc(stream);
        do_load(0, 0, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Configuration sequencer for the IO-tile CCFF chains. It takes bitstream words over a valid/ready handshake and serializes them onto ccff_head while gating config_enable.
- After exactly CHAIN_LEN bits have been shifted, and SETTLE_CYC idle cycles have passed, it raises CFG_DONE.
- Sits between the bitstream source and the head of the chained pad config memories. It is the only driver of config_enable and CFG_DONE for those tiles.

Parameters:
- CHAIN_LEN, 64: total config bits in the chain (4 per pad); must be >=1.
- WORD_W, 8: bitstream input word width; must be >=1.
- SETTLE_CYC, 2: idle cycles between the last shift and CFG_DONE rising; 0 is allowed.

Ports:
- prog_clock  in  1  programming clock; all state updates on its rising edge
- pReset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse that begins a load
- abort  in  1  single-cycle pulse that cancels a load in progress
- din  in  WORD_W  bitstream word; bit 0 is shifted first
- din_valid  in  1  din holds a valid word
- din_ready  out  1  loader accepts din this cycle
- ccff_head  out  1  serial config bit to the head of the chain
- config_enable  out  1  chain shift enable
- CFG_DONE  out  1  configuration complete
- busy  out  1  loader is in LOAD or SETTLE
- bits_left  out  $clog2(CHAIN_LEN+1)  bits still to shift

Behaviour:
- Reset values (async on pReset): state=IDLE, all outputs 0, bits_left=0, internal word buffer empty.
- States: IDLE, LOAD, SETTLE, DONE (plus ERROR when CFG_CRC_EN is defined).
- IDLE or DONE, on start:
  - go to LOAD; bits_left=CHAIN_LEN; CFG_DONE=0 on the next cycle.
  - start while in LOAD or SETTLE is ignored.
- LOAD, input buffering:
  - One-word buffer plus a bit index.
  - din_ready=1 when the buffer is empty or being emptied this cycle, and bits_left covers more than the bits already held in the buffer.
  - A word is accepted on din_valid && din_ready.
- LOAD, shifting:
  - In any cycle where the buffer holds an unshifted bit: ccff_head=that bit, config_enable=1, bits_left decrements by 1.
  - Buffer bits are shifted LSB first, one bit per cycle.
  - With no buffered bit (stall): config_enable=0, so the chain holds its contents, and ccff_head holds its last value.
  - Latency: the first bit appears on ccff_head/config_enable in the cycle after the first word is accepted.
  - With din_valid held high, throughput is 1 bit per cycle with no bubbles: the next word is accepted in the same cycle the last buffered bit shifts.
- Partial final word: if CHAIN_LEN is not a multiple of WORD_W, the upper bits of the final word are discarded, never shifted. din_ready=0 once all needed words are accepted.
- When bits_left reaches 0 after a shift, go to SETTLE:
  - config_enable=0; count SETTLE_CYC cycles, then go to DONE with CFG_DONE=1.
  - SETTLE_CYC=0 means DONE is entered directly from LOAD, in the cycle after the last shift.
- DONE: CFG_DONE stays 1 until start or pReset; din_ready=0.
- abort in LOAD or SETTLE: return to IDLE next cycle; config_enable=0, buffer flushed, CFG_DONE=0, bits_left=0.
- abort and start in the same cycle: abort wins.
- busy=1 exactly in LOAD and SETTLE.
- pReset mid-load: immediate return to reset values. The chain contents are undefined and a full reload is required.

Optional Feature:
- Macro: CFG_CRC_EN.
- When defined:
  - Adds input port crc_expected[15:0], sampled at start.
  - A CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection) is updated bit-serially with each shifted ccff_head bit.
  - At the end of SETTLE: match goes to DONE; mismatch goes to ERROR with CFG_DONE=0.
  - Adds output crc_err (reset 0, =1 in ERROR). ERROR exits only on start or pReset.
- When undefined: no CRC logic or ports; SETTLE always goes to DONE.

Decomposition:
- Package ccff_loader_pkg holds:
  - the state enum (IDLE, LOAD, SETTLE, DONE, ERROR);
  - the CRC16 polynomial and init constants;
  - the function crc16_step(crc, bit).
- One natural sub-module: ccff_word_serializer, holding the word buffer, bit index and the din_ready/shift-valid logic. The top keeps the FSM, counters and CRC.

Test Plan:
- CHAIN_LEN=20, WORD_W=8, din_valid always high, words 0xA5, 0x3C, 0xF7 -> 20 consecutive config_enable cycles; ccff_head sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,0; exactly 3 words accepted; CFG_DONE rises SETTLE_CYC+1 cycles after the last shift.
- Same load with din_valid dropped for 5 cycles mid-word-2 -> config_enable=0 for exactly those stall cycles; shifted bit sequence unchanged; total 20 enable cycles.
- abort asserted at bits_left=7 -> IDLE next cycle; config_enable=0, bits_left=0, CFG_DONE=0. A following start reloads all 20 bits.
- start pulsed while busy, and start+abort in the same cycle -> start ignored / abort wins; bits_left trajectory unaffected in the ignored case.
- pReset asserted asynchronously mid-SETTLE -> all outputs 0 immediately, without waiting for a clock edge.
- CFG_CRC_EN defined: crc_expected equal to the computed CRC -> CFG_DONE=1. One bit of crc_expected flipped -> ERROR, crc_err=1, CFG_DONE=0; a new start clears crc_err.
